uart_hex_reporter: RTL

Transmit-side companion to the UART LED display path: formats an 8-bit value as ASCII text (`0x`, two hex digits, optional CR LF). It streams the bytes one at a time into the existing `uart` transmitter through its `tx_data_i` / `tx_trigger_i` / `tx_complete_o` port trio. It sits in a top level between user logic (button, counter, latched RX byte) and the `uart` instance, so the board can report values back to the host.

---
 rtl/uart_pkg.sv | 12 +
 rtl/hex_nibble_ascii.sv | 11 +
 rtl/uart_hex_reporter.sv | 83 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: ASCII constants and reporter FSM encoding shared by the UART transmit path.
package uart_pkg;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_X    = 8'h78;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_RDY, FIRE, GUARD, WAIT_DONE, DONE
  } state_t;
endpackage

// File: rtl/hex_nibble_ascii.sv
// hex_nibble_ascii: maps a nibble to its ASCII hex digit, upper or lower case.
module hex_nibble_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       upper,
  output logic [7:0] ascii
);
  always_comb ascii = (nibble < 4'd10) ? ASCII_0 + {4'd0, nibble}
                    : (upper ? ASCII_A_UP : ASCII_A_LO) + {4'd0, nibble} - 8'd10;
endmodule

// File: rtl/uart_hex_reporter.sv
// uart_hex_reporter: streams "0x" + two hex digits (+ optional CR LF) of a byte into a UART transmitter.
module uart_hex_reporter
  import uart_pkg::*;
#(
  parameter bit HEX_UPPER    = 1'b1,
  parameter bit APPEND_CRLF  = 1'b1,
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] value_i,
  input  logic       send_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] tx_data_o,
  output logic       tx_trigger_o,
  input  logic       tx_ready_i
);
  localparam logic [2:0] LAST = APPEND_CRLF ? 3'd5 : 3'd3;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] val_q, val_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] hi, lo, byte_d;
  // Digits are built from the next-cycle value so LOAD presents the byte immediately.
  hex_nibble_ascii u_hi (.nibble(val_d[7:4]), .upper(HEX_UPPER), .ascii(hi));
  hex_nibble_ascii u_lo (.nibble(val_d[3:0]), .upper(HEX_UPPER), .ascii(lo));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      val_q        <= '0;
      cnt_q        <= '0;
      tx_data_o    <= '0;
      tx_trigger_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      cnt_q        <= cnt_d;
      tx_data_o    <= (state_d == LOAD) ? byte_d : tx_data_o;
      tx_trigger_o <= state_d == FIRE;
      busy_o       <= state_d != IDLE;
      done_o       <= state_d == DONE;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (send_i) begin
        val_d   = value_i;
        idx_d   = '0;
        state_d = LOAD;
      end
      LOAD:     state_d = WAIT_RDY;
      WAIT_RDY: state_d = tx_ready_i ? FIRE : WAIT_RDY;
      FIRE: begin
        cnt_d   = GUARD_CYCLES[3:0];
        state_d = GUARD;
      end
      GUARD: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? WAIT_DONE : GUARD;
      end
      WAIT_DONE: if (tx_ready_i) begin
        idx_d   = (idx_q == LAST) ? idx_q : idx_q + 3'd1;
        state_d = (idx_q == LAST) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb
    byte_d = (idx_d == 3'd0) ? ASCII_0
           : (idx_d == 3'd1) ? ASCII_X
           : (idx_d == 3'd2) ? hi
           : (idx_d == 3'd3) ? lo
           : (idx_d == 3'd4) ? ASCII_CR : ASCII_LF;
endmodule
